map_read_scheduler: RTL
=======================

// Module: map_read_scheduler
// PURPOSE
// - Sequences activation reads feeding map_generator: walks 4x4-pixel conv windows over a feature map in bank-interleaved SRAM (2x2 blocks of 2x2 px).
// - Per window: issues one address to each of banks 0..3. Then steps channel 0..CH_NUM-1, one per cycle.
// - Emits map_type_delay and base_0..3 aligned with the registered SRAM read data (sram_rdata_*_delay), plus a valid strobe for the PE array.
// - Bank set (A or B) is selected by the top FSM; this block is bank-set agnostic.
// PARAMETERS
// - CH_NUM        24  channels per SRAM word
// - ACT_PER_ADDR   4  pixels (2x2) per channel per word
// - BW_PER_ACT    16  bits per activation
// - BASE_BW       11  width of base_k bit indices
// - ADDR_BW       10  SRAM address width
// - DIM_BW         6  width of block-dimension config
// - RD_LAT         2  cycles from address issue to *_delay data (SRAM 1 + register 1)
// PORTS
// - clk            in   1        clock, rising edge
// - rst_n          in   1        async active-low reset
// - start          in   1        1-cycle pulse; latches h_blk/w_blk and begins a layer pass
// - hold           in   1        high = issue no new read this cycle (bubble)
// - h_blk          in   DIM_BW   map height in 2x2 blocks
// - w_blk          in   DIM_BW   map width in 2x2 blocks
// - sram_re        out  1        read enable, all four banks
// - sram_raddr_0..3 out ADDR_BW  read address for bank 0..3
// - map_type_delay out  2        {row_odd,col_odd} of window top-left block, delayed RD_LAT
// - base_0..3      out  BASE_BW  MSB bit index of pixel k of current channel, delayed RD_LAT
// - map_valid      out  1        map_* from map_generator is valid this cycle
// - busy           out  1        high from start accept until done
// - done           out  1        1-cycle pulse after last valid beat
// BEHAVIOUR
// - Reset: all outputs 0; FSM in IDLE; counters 0. Reset mid-pass aborts immediately, no done.
// - FSM: IDLE -start-> RUN. RUN -last issue-> DRAIN. DRAIN (RD_LAT cycles) -> DONE. DONE (1 cycle, done=1) -> IDLE.
// - start outside IDLE is ignored.
// - Config check: h_blk<2 or w_blk<2 means zero windows; IDLE->DONE directly, no sram_re, no map_valid.
// - Loop order: ch (0..CH_NUM-1) innermost, then col c (0..w_blk-2), then row r (0..h_blk-2). Stride is 1 block.
// - Issue cycle (RUN & !hold): sram_re=1. Counters advance only on issue; hold freezes counters and inserts a bubble.
// - Addressing: WH = ceil(w_blk/2). For bank j:
//   - row = r + (j[1]^r[0]); col = c + (j[0]^c[0])
//   - raddr_j = (row>>1)*WH + (col>>1)
//   - Addresses are constant across the ch loop of a window.
// - map_type = {r[0],c[0]}, i.e. the bank holding the top-left block.
// - base_k = (CH_NUM*ACT_PER_ADDR-1 - (ch*ACT_PER_ADDR+k))*BW_PER_ACT + BW_PER_ACT-1. Unsigned, fits BASE_BW.
// - Alignment: map_type, base_k and issue-valid pass through an RD_LAT-deep register pipe.
//   - map_valid(t+RD_LAT) = issue(t). The pipe keeps shifting during hold and DRAIN.
// - done asserts exactly RD_LAT+1 cycles after the final issue. busy falls in the same cycle done rises.
// - Arithmetic: row/col use DIM_BW+1 bits; raddr is truncated to ADDR_BW. The top level guarantees the map fits.
// STRUCTURE
// - Shared include: top-FSM state codes (IDLE..FINISH), ACT_PER_ADDR, BW_PER_ACT, RD_LAT.
// - Sub-module map_addr_calc (combinational): r, c, ch, WH -> raddr_0..3, map_type, base_0..3.
// - The top of this block holds the FSM, counters and the RD_LAT alignment pipe.
// TESTING
// - Reset: rst_n=0 mid-RUN -> next cycle all outputs 0, busy=0, no done; restart works cleanly.
// - Full pass: h_blk=4, w_blk=4, no hold -> 9 windows x 24 = 216 map_valid beats, contiguous.
//   - done at issue_last + 3.
// - Window (r=1,c=1), w_blk=4 -> raddr_0..3 = 3,2,1,0; map_type=3.
//   - ch=0: base_0..3 = 1535,1519,1503,1487. ch=23: base_3 = 15.
// - Hold: toggle hold every other cycle on the 4x4 pass -> still exactly 216 valid beats, same sequence.
//   - map_valid has gaps matching the holds; done after the last.
// - Degenerate config: h_blk=1, w_blk=5, start -> done the cycle after DONE entry, zero sram_re and zero map_valid.
// - Busy start: start pulse during RUN -> ignored; the counter sequence is unchanged.

Source files
------------

// File: rtl/map_read_scheduler_pkg.sv
// Shared constants and FSM state codes for the map read scheduler.
// Holds the feature-map geometry, datapath widths, the read latency that
// the alignment pipe must match, and the scheduler state encoding.
package map_read_scheduler_pkg;

  localparam int CH_NUM       = 24;  // channels per SRAM word
  localparam int ACT_PER_ADDR = 4;   // 2x2 pixels per channel per word
  localparam int BW_PER_ACT   = 16;  // bits per activation
  localparam int BASE_BW      = 11;  // width of base_k bit indices
  localparam int ADDR_BW      = 10;  // SRAM address width
  localparam int DIM_BW       = 6;   // block-dimension config width
  localparam int RD_LAT       = 2;   // address issue -> *_delay data
  localparam int NUM_BANKS    = 4;

  localparam int CH_BW    = $clog2(CH_NUM);
  localparam int DRAIN_BW = $clog2(RD_LAT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_t;

endpackage

// File: rtl/map_read_scheduler_addr_calc.sv
// Combinational address / bit-index generator for one read beat.
// Ports:
//   r, c      window top-left block row / column
//   ch        channel within the SRAM word
//   wh        words per block-pair row, ceil(w_blk/2)
//   raddr     read address for banks 0..3
//   map_type  {row_odd, col_odd} of the top-left block
//   base      MSB bit index of pixel 0..3 of channel ch
module map_read_scheduler_addr_calc
  import map_read_scheduler_pkg::*;
(
  input  logic [DIM_BW-1:0]                    r,
  input  logic [DIM_BW-1:0]                    c,
  input  logic [CH_BW-1:0]                     ch,
  input  logic [DIM_BW-1:0]                    wh,
  output logic [NUM_BANKS-1:0][ADDR_BW-1:0]    raddr,
  output logic [1:0]                           map_type,
  output logic [ACT_PER_ADDR-1:0][BASE_BW-1:0] base
);

  localparam int PROD_BW = 2 * DIM_BW + 1;

  assign map_type = {r[0], c[0]};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
      localparam logic [1:0] J = 2'(gi);
      logic [DIM_BW:0] row;
      logic [DIM_BW:0] col;

      // A window spans block rows r..r+1 and cols c..c+1; bank j owns the
      // block whose row parity is J[1] and column parity is J[0].
      assign row = {1'b0, r} + {{DIM_BW{1'b0}}, J[1] ^ r[0]};
      assign col = {1'b0, c} + {{DIM_BW{1'b0}}, J[0] ^ c[0]};

      assign raddr[gi] = ADDR_BW'(PROD_BW'(row >> 1) * PROD_BW'(wh)
                                  + PROD_BW'(col >> 1));
    end

    for (gi = 0; gi < ACT_PER_ADDR; gi++) begin : g_pix
      logic [BASE_BW-1:0] act_idx;

      // Activations are packed MSB-first: channel 0 pixel 0 sits on top.
      assign act_idx = BASE_BW'(ch) * BASE_BW'(ACT_PER_ADDR) + BASE_BW'(gi);
      assign base[gi] = (BASE_BW'(CH_NUM * ACT_PER_ADDR - 1) - act_idx)
                        * BASE_BW'(BW_PER_ACT) + BASE_BW'(BW_PER_ACT - 1);
    end
  endgenerate

endmodule

// File: rtl/map_read_scheduler.sv
// Activation read sequencer for map_generator.
// Walks 2x2-block conv windows (stride 1 block) over a bank-interleaved
// feature map, issuing one read per channel per window, and delays the
// per-beat tags so they line up with the registered SRAM read data.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   start             1-cycle pulse, latches h_blk/w_blk, starts a pass
//   hold              suppress the read this cycle (bubble)
//   h_blk, w_blk      map height / width in 2x2 blocks
//   sram_re           read enable for all four banks
//   sram_raddr_0..3   per-bank read address
//   map_type_delay    {row_odd,col_odd} of the window, aligned with data
//   base_0..3         pixel MSB bit indices, aligned with data
//   map_valid         aligned beat strobe for the PE array
//   busy, done        pass in progress / 1-cycle completion pulse
module map_read_scheduler
  import map_read_scheduler_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               hold,
  input  logic [DIM_BW-1:0]  h_blk,
  input  logic [DIM_BW-1:0]  w_blk,
  output logic               sram_re,
  output logic [ADDR_BW-1:0] sram_raddr_0,
  output logic [ADDR_BW-1:0] sram_raddr_1,
  output logic [ADDR_BW-1:0] sram_raddr_2,
  output logic [ADDR_BW-1:0] sram_raddr_3,
  output logic [1:0]         map_type_delay,
  output logic [BASE_BW-1:0] base_0,
  output logic [BASE_BW-1:0] base_1,
  output logic [BASE_BW-1:0] base_2,
  output logic [BASE_BW-1:0] base_3,
  output logic               map_valid,
  output logic               busy,
  output logic               done
);

  state_t state_reg, state_next;

  logic [DIM_BW-1:0]   h_reg, w_reg, r_reg, c_reg;
  logic [CH_BW-1:0]    ch_reg;
  logic [DRAIN_BW-1:0] drain_reg;
  logic [DIM_BW-1:0]   wh;
  logic                issue, last_beat, cfg_ok, start_accept;

  logic [NUM_BANKS-1:0][ADDR_BW-1:0]    calc_raddr;
  logic [1:0]                           calc_type;
  logic [ACT_PER_ADDR-1:0][BASE_BW-1:0] calc_base;

  logic                                 valid_pipe [RD_LAT];
  logic [1:0]                           type_pipe  [RD_LAT];
  logic [ACT_PER_ADDR-1:0][BASE_BW-1:0] base_pipe  [RD_LAT];

  assign wh           = (w_reg >> 1) + DIM_BW'(w_reg[0]);
  assign cfg_ok       = (h_blk >= DIM_BW'(2)) && (w_blk >= DIM_BW'(2));
  assign start_accept = (state_reg == IDLE) && start;
  assign last_beat    = (ch_reg == CH_BW'(CH_NUM - 1))
                        && (c_reg == w_reg - DIM_BW'(2))
                        && (r_reg == h_reg - DIM_BW'(2));

  map_read_scheduler_addr_calc u_calc (
    .r        (r_reg),
    .c        (c_reg),
    .ch       (ch_reg),
    .wh       (wh),
    .raddr    (calc_raddr),
    .map_type (calc_type),
    .base     (calc_base)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    issue      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        // A map smaller than 2x2 blocks has no window: finish straight away.
        if (start) state_next = cfg_ok ? RUN : FINISH;
      end
      RUN: begin
        busy  = 1'b1;
        issue = !hold;
        if (!hold && last_beat) state_next = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (drain_reg == DRAIN_BW'(RD_LAT - 1)) state_next = FINISH;
      end
      FINISH: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign sram_re = issue;

  // Addresses are forced to zero on non-issue cycles so the bus is quiet.
  assign sram_raddr_0 = issue ? calc_raddr[0] : '0;
  assign sram_raddr_1 = issue ? calc_raddr[1] : '0;
  assign sram_raddr_2 = issue ? calc_raddr[2] : '0;
  assign sram_raddr_3 = issue ? calc_raddr[3] : '0;

  // Loop counters: ch innermost, then column, then row; they move only on issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_reg     <= '0;
      w_reg     <= '0;
      r_reg     <= '0;
      c_reg     <= '0;
      ch_reg    <= '0;
      drain_reg <= '0;
    end else begin
      if (start_accept) begin
        h_reg  <= h_blk;
        w_reg  <= w_blk;
        r_reg  <= '0;
        c_reg  <= '0;
        ch_reg <= '0;
      end else if (issue) begin
        if (ch_reg == CH_BW'(CH_NUM - 1)) begin
          ch_reg <= '0;
          if (c_reg == w_reg - DIM_BW'(2)) begin
            c_reg <= '0;
            r_reg <= r_reg + DIM_BW'(1);
          end else begin
            c_reg <= c_reg + DIM_BW'(1);
          end
        end else begin
          ch_reg <= ch_reg + CH_BW'(1);
        end
      end
      drain_reg <= (state_reg == DRAIN) ? drain_reg + DRAIN_BW'(1) : '0;
    end
  end

  // Alignment pipe: shifts every cycle so holds appear as gaps in map_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) begin
        valid_pipe[i] <= 1'b0;
        type_pipe[i]  <= '0;
        base_pipe[i]  <= '0;
      end
    end else begin
      valid_pipe[0] <= issue;
      type_pipe[0]  <= calc_type;
      base_pipe[0]  <= calc_base;
      for (int i = 1; i < RD_LAT; i++) begin
        valid_pipe[i] <= valid_pipe[i-1];
        type_pipe[i]  <= type_pipe[i-1];
        base_pipe[i]  <= base_pipe[i-1];
      end
    end
  end

  assign map_valid      = valid_pipe[RD_LAT-1];
  assign map_type_delay = type_pipe[RD_LAT-1];
  assign base_0         = base_pipe[RD_LAT-1][0];
  assign base_1         = base_pipe[RD_LAT-1][1];
  assign base_2         = base_pipe[RD_LAT-1][2];
  assign base_3         = base_pipe[RD_LAT-1][3];

endmodule
